// File: rtl/afifo_pkg.sv
// afifo_pkg: shared pointer width, pointer type and Gray-encode helper for the async FIFO.
package afifo_pkg;
  localparam int ADDRSIZE_DEF = 4;
  typedef logic [ADDRSIZE_DEF:0] ptr_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/wptr_full_gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder of parameterised width.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);
  always_comb begin
    b = '0;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
  end
endmodule

// File: rtl/wptr_full.sv
// wptr_full: write-side pointer, full/free/overflow tracking of an async FIFO.
// Define AFIFO_ALMOST_FULL_EN to build the registered almost-full flag.
module wptr_full
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE       = ADDRSIZE_DEF,
  parameter int ALMOST_FULL_TH = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_wclk,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wen,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wfree,
  output logic                wovf
);
  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
  logic [ADDRSIZE:0] wbin_q, wbin_d, wptr_q, wptr_d, wfree_q, wfree_d, rbin;
  logic              wfull_q, wfull_d, wovf_q, wovf_d;
  gray2bin #(.W(ADDRSIZE + 1)) u_rptr_dec (.g(rptr_wclk), .b(rbin));
  assign wen = winc & ~wfull_q;
  // Full compares the next Gray write pointer with the read pointer, top two bits inverted.
  always_comb begin
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    wptr_d  = (ADDRSIZE + 1)'(bin2gray(32'(wbin_d)));
    wfull_d = wptr_d == {~rptr_wclk[ADDRSIZE:ADDRSIZE-1], rptr_wclk[ADDRSIZE-2:0]};
    wfree_d = DEPTH - (wbin_d - rbin);
    wovf_d  = wovf_q | (winc & wfull_q);
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      wfree_q <= DEPTH;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
      wfree_q <= wfree_d;
      wovf_q  <= wovf_d;
    end
  end
`ifdef AFIFO_ALMOST_FULL_EN
  logic walmost_q, walmost_d;
  assign walmost_d = wfree_d <= (ADDRSIZE + 1)'(ALMOST_FULL_TH);
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) walmost_q <= 1'b0;
    else walmost_q <= walmost_d;
  end
  assign walmost_full = walmost_q;
`else
  assign walmost_full = 1'b0;
`endif
  assign wptr  = wptr_q;
  assign waddr = wbin_q[ADDRSIZE-1:0];
  assign wfull = wfull_q;
  assign wfree = wfree_q;
  assign wovf  = wovf_q;
endmodule
